// File: rtl/obi_mgr_shim_pkg.sv
// Shared types for the OBI manager shim: bus configuration, request/response
// structs and the response-buffer entry.
package obi_mgr_shim_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned IdWidth   = 4;

  typedef struct packed {
    logic        UseRReady;
    logic        UseAtop;
    logic        Integrity;
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady: 1'b1,
    UseAtop:   1'b1,
    Integrity: 1'b0,
    AddrWidth: 32,
    DataWidth: 32,
    IdWidth:   4
  };

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [IdWidth-1:0]     aid;
    logic [5:0]             atop;
    logic [2:0]             prot;
    logic [1:0]             memtype;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
    logic        rready;
  } obi_mgr_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_mgr_rsp_t;

  typedef struct packed {
    logic                 err;
    logic [DataWidth-1:0] rdata;
  } rsp_entry_t;

  // IDs wrap naturally at 2^IdWidth.
  function automatic logic [IdWidth-1:0] id_next(input logic [IdWidth-1:0] id);
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/obi_mgr_shim_if.sv
// Local SRAM-style port of the OBI manager shim (req/gnt, in-order rvalid).
interface obi_mgr_shim_if;
  import obi_mgr_shim_pkg::*;

  logic                   req;
  logic                   gnt;
  logic                   we;
  logic [AddrWidth-1:0]   addr;
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] be;
  logic                   rvalid;
  logic                   rready;
  logic [DataWidth-1:0]   rdata;
  logic                   err;

  modport master (
    output req, we, addr, wdata, be, rready,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be, rready,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/obi_mgr_shim_fifo.sv
// Small non-fall-through FIFO used to buffer responses when the local
// response-FIFO build option (OBI_MGR_SHIM_RSP_FIFO_EN) is enabled.
module obi_mgr_shim_fifo #(
  parameter int unsigned Depth      = 2,
  parameter int unsigned Width      = 8,
  parameter int unsigned UsageWidth = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [Width-1:0]      data_i,
  input  logic                  pop_i,
  output logic [Width-1:0]      data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [UsageWidth-1:0] usage_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]      mem_q [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [UsageWidth-1:0] usage_q, usage_d;
  logic                  push_ok, pop_ok;

  function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (usage_q == UsageWidth'(Depth));
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and fill-level next state.
  always_comb begin
    wr_ptr_d = push_ok ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_next(rd_ptr_q) : rd_ptr_q;
    usage_d  = usage_q;
    if (push_ok && !pop_ok) begin
      usage_d = usage_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      usage_d = usage_q - 1'b1;
    end
  end

  // Control state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Storage; contents are only meaningful while counted in usage_q.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/obi_mgr_shim.sv
// OBI manager shim: bridges an SRAM-style local port onto an OBI manager port.
// Outstanding transactions are limited by a credit counter, AIDs increment per
// handshake and response RIDs are checked for in-order arrival.
// Build option OBI_MGR_SHIM_RSP_FIFO_EN adds a response FIFO honouring rready.
module obi_mgr_shim
  import obi_mgr_shim_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg         = ObiDefaultConfig,
  parameter type         obi_req_t      = obi_mgr_req_t,
  parameter type         obi_rsp_t      = obi_mgr_rsp_t,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  obi_mgr_shim_if.slave   lcl,
  output logic            id_err_o,
  output obi_req_t        obi_req_o,
  input  obi_rsp_t        obi_rsp_i
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth:0] MaxOut = (CntWidth + 1)'(MaxOutstanding);

  if (ObiCfg.Integrity) begin : gen_err_integrity
    $error("obi_mgr_shim: integrity signals are not supported");
  end
  if (MaxOutstanding < 1) begin : gen_err_max_out
    $error("obi_mgr_shim: MaxOutstanding must be at least 1");
  end
  if (ObiCfg.AddrWidth != AddrWidth || ObiCfg.DataWidth != DataWidth ||
      ObiCfg.IdWidth != IdWidth) begin : gen_err_widths
    $error("obi_mgr_shim: ObiCfg widths do not match the bus structs");
  end

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [IdWidth-1:0]  aid_q, aid_d, exp_rid_q, exp_rid_d;
  logic                id_err_q, id_err_d;
  logic [CntWidth-1:0] occupancy;
  logic                credit_ok, hs, rsp_valid;

  // Buffered responses still hold a credit until the local side takes them.
  assign credit_ok = ({1'b0, cnt_q} + {1'b0, occupancy}) < MaxOut;
  assign hs        = obi_req_o.req & obi_rsp_i.gnt;
  assign rsp_valid = obi_rsp_i.rvalid;
  assign lcl.gnt   = hs;
  assign id_err_o  = id_err_q;

  // Request channel: pass-through with credit gating and our own AID.
  always_comb begin
    obi_req_o           = '0;
    obi_req_o.req       = lcl.req & credit_ok;
    obi_req_o.a.addr    = lcl.addr;
    obi_req_o.a.we      = lcl.we;
    obi_req_o.a.be      = lcl.be;
    obi_req_o.a.wdata   = lcl.wdata;
    obi_req_o.a.aid     = aid_q;
    obi_req_o.a.atop    = '0;
    obi_req_o.a.prot    = '0;
    obi_req_o.a.memtype = '0;
    // Credits guarantee space for every response, so never backpressure.
    obi_req_o.rready    = ObiCfg.UseRReady;
  end

  // Outstanding count, ID tracking and sticky RID-mismatch flag.
  always_comb begin
    cnt_d = cnt_q;
    if (hs && !rsp_valid) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!hs && rsp_valid && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    aid_d     = hs ? id_next(aid_q) : aid_q;
    exp_rid_d = rsp_valid ? id_next(exp_rid_q) : exp_rid_q;
    id_err_d  = id_err_q | (rsp_valid & (obi_rsp_i.r.rid != exp_rid_q));
  end

  // Tracking state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      aid_q     <= '0;
      exp_rid_q <= '0;
      id_err_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      aid_q     <= aid_d;
      exp_rid_q <= exp_rid_d;
      id_err_q  <= id_err_d;
    end
  end

`ifdef OBI_MGR_SHIM_RSP_FIFO_EN
  rsp_entry_t push_data, pop_data;
  logic       fifo_full, fifo_empty, fifo_pop;

  assign push_data.err   = obi_rsp_i.r.err;
  assign push_data.rdata = obi_rsp_i.r.rdata;
  assign lcl.rvalid      = ~fifo_empty;
  assign lcl.rdata       = pop_data.rdata;
  assign lcl.err         = pop_data.err;
  assign fifo_pop        = lcl.rvalid & lcl.rready;

  obi_mgr_shim_fifo #(
    .Depth      (MaxOutstanding),
    .Width      ($bits(rsp_entry_t)),
    .UsageWidth (CntWidth)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rsp_valid),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .data_o  (pop_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (occupancy)
  );

  rsp_fifo_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni) rsp_valid |-> !fifo_full);
`else
  logic unused_rready;

  assign lcl.rvalid    = rsp_valid;
  assign lcl.rdata     = obi_rsp_i.r.rdata;
  assign lcl.err       = obi_rsp_i.r.err;
  assign occupancy     = '0;
  assign unused_rready = lcl.rready;
`endif

  rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) rsp_valid |-> (cnt_q != '0));

endmodule
